// File: rtl/counter_ctrl.sv
// counter_ctrl: run/stop/clear controlled up/down counter driven by a tick prescaler.
//
// state | meaning
// STOP  | idle; prescaler and count hold, so a paused run resumes mid-period
// RUN   | prescaler advances; count steps when the prescaler reaches DIV-1
// CLEAR | single pass that zeroes count and prescaler, then returns to STOP
module counter_ctrl #(
  parameter int unsigned DIV       = 10_000_000,
  parameter int unsigned MAX_COUNT = 9999
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_run_stop,
  input  logic        i_clear,
  input  logic        i_mode_down,
  output logic [13:0] o_counter,
  output logic        o_run,
  output logic        o_tick,
  output logic        o_wrap
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  localparam logic [23:0] PRESC_LAST = 24'(DIV - 1);
  localparam logic [13:0] CNT_MAX    = 14'(MAX_COUNT);

  state_t      state_q, state_d;
  logic [23:0] presc_q, presc_d;
  logic [13:0] count_q, count_d;
  logic        tick_q, tick_d;
  logic        wrap_q, wrap_d;
  logic        terminal;

  // State register; reset lands in STOP so o_run drops with reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= ST_STOP;
    else            state_q <= state_d;
  end

  // Next-state logic; clear outranks run/stop in STOP, and is ignored in RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: begin
        if (i_clear)         state_d = ST_CLEAR;
        else if (i_run_stop) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (i_run_stop) state_d = ST_STOP;
      end
      ST_CLEAR: state_d = ST_STOP;
      default:  state_d = ST_STOP;
    endcase
  end

  // State-decoded output.
  always_comb begin
    o_run = (state_q == ST_RUN);
  end

  // Prescaler and count next values; a terminal event still updates the
  // count when run/stop lands on the same edge.
  always_comb begin
    terminal = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
    presc_d  = presc_q;
    count_d  = count_q;
    tick_d   = 1'b0;
    wrap_d   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (terminal) begin
          presc_d = '0;
          tick_d  = 1'b1;
          if (i_mode_down) begin
            if (count_q == '0 || count_q > CNT_MAX) begin
              count_d = CNT_MAX;
              wrap_d  = 1'b1;
            end else begin
              count_d = count_q - 14'd1;
            end
          end else begin
            if (count_q >= CNT_MAX) begin
              count_d = '0;
              wrap_d  = 1'b1;
            end else begin
              count_d = count_q + 14'd1;
            end
          end
        end else begin
          presc_d = presc_q + 24'd1;
        end
      end
      ST_CLEAR: begin
        presc_d = '0;
        count_d = '0;
      end
      default: ;
    endcase
  end

  // Datapath registers; reset discards any partial prescaler period.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      presc_q <= '0;
      count_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign o_counter = count_q;
  assign o_tick    = tick_q;
  assign o_wrap    = wrap_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Testbench for counter_ctrl with DIV=4, MAX_COUNT=9999.
module tb_counter_ctrl;

  localparam int DIV  = 4;
  localparam int MAXC = 9999;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_run_stop;
  logic        i_clear;
  logic        i_mode_down;
  logic [13:0] o_counter;
  logic        o_run;
  logic        o_tick;
  logic        o_wrap;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: running flag, clear-pending flag, cycles into the
  // current tick period, and the count value.
  bit m_run, m_clr, m_tick, m_wrap;
  int m_phase, m_cnt;

  typedef struct {
    int rs;
    int clr;
    int md;
    int cnt;
    int run;
    int tick;
    int wrap;
  } vec_t;

  vec_t vecs[$];

  counter_ctrl #(.DIV(DIV), .MAX_COUNT(MAXC)) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_run_stop  (i_run_stop),
    .i_clear     (i_clear),
    .i_mode_down (i_mode_down),
    .o_counter   (o_counter),
    .o_run       (o_run),
    .o_tick      (o_tick),
    .o_wrap      (o_wrap)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_clr = 0; m_tick = 0; m_wrap = 0; m_phase = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit rs, input bit clr, input bit md);
    m_tick = 0;
    m_wrap = 0;
    if (m_clr) begin
      m_clr = 0; m_cnt = 0; m_phase = 0;
    end else if (m_run) begin
      if (m_phase == DIV - 1) begin
        m_tick  = 1;
        m_phase = 0;
        if (md) begin
          m_wrap = (m_cnt == 0);
          m_cnt  = (m_cnt + MAXC) % (MAXC + 1);
        end else begin
          m_wrap = (m_cnt == MAXC);
          m_cnt  = (m_cnt + 1) % (MAXC + 1);
        end
      end else begin
        m_phase = m_phase + 1;
      end
      if (rs) m_run = 0;
    end else begin
      if (clr)     m_clr = 1;
      else if (rs) m_run = 1;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_cnt"},  int'(o_counter), 0);
    chk({tag, "_run"},  int'(o_run), 0);
    chk({tag, "_tick"}, int'(o_tick), 0);
    chk({tag, "_wrap"}, int'(o_wrap), 0);
  endtask

  // One clock: drive inputs, advance the model at the edge, compare after it.
  task automatic step(input bit rs, input bit clr, input bit md);
    i_run_stop  = rs;
    i_clear     = clr;
    i_mode_down = md;
    @(posedge i_clk);
    model_edge(rs, clr, md);
    #1;
    i_run_stop = 0;
    i_clear    = 0;
    chk("cyc_cnt",  int'(o_counter), m_cnt);
    chk("cyc_run",  int'(o_run), int'(m_run));
    chk("cyc_tick", int'(o_tick), int'(m_tick));
    chk("cyc_wrap", int'(o_wrap), int'(m_wrap));
  endtask

  // Step until the model ticks; mode is random except at the terminal cycle.
  task automatic run_to_tick(input bit md, input string tag);
    bit seen;
    bit md_now;
    seen = 0;
    for (int k = 0; k < 2 * DIV && !seen; k++) begin
      if (m_run && !m_clr && m_phase == DIV - 1) md_now = md;
      else                                       md_now = bit'($urandom_range(0, 1));
      step(0, 0, md_now);
      seen = m_tick;
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: no tick within %0d cycles", tag, 2 * DIV);
    end
  endtask

  task automatic add_vec(input int rs, input int clr, input int md,
                         input int cnt, input int run, input int tick, input int wrap);
    vec_t v;
    v.rs = rs; v.clr = clr; v.md = md;
    v.cnt = cnt; v.run = run; v.tick = tick; v.wrap = wrap;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    i_reset_n = 0; i_run_stop = 0; i_clear = 0; i_mode_down = 0;
    model_reset();
    #3;
    check_zero("rst_init");
    #9;
    i_reset_n = 1;

    // rs, clr, md -> cnt, run, tick, wrap (after the edge)
    add_vec(1, 0, 0, 0, 1, 0, 0);
    add_vec(0, 0, 0, 0, 1, 0, 0);
    add_vec(0, 0, 0, 0, 1, 0, 0);
    add_vec(0, 0, 0, 0, 1, 0, 0);
    add_vec(0, 0, 0, 1, 1, 1, 0);
    add_vec(0, 0, 0, 1, 1, 0, 0);
    add_vec(0, 0, 0, 1, 1, 0, 0);
    add_vec(0, 0, 0, 1, 1, 0, 0);
    add_vec(0, 0, 0, 2, 1, 1, 0);
    add_vec(1, 0, 0, 2, 0, 0, 0);
    add_vec(1, 1, 0, 2, 0, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0);
    add_vec(1, 0, 0, 0, 1, 0, 0);
    add_vec(0, 1, 0, 0, 1, 0, 0);
    add_vec(0, 0, 0, 0, 1, 0, 0);
    add_vec(0, 0, 0, 0, 1, 0, 0);
    add_vec(0, 0, 0, 1, 1, 1, 0);
    add_vec(0, 0, 0, 1, 1, 0, 0);
    add_vec(0, 0, 0, 1, 1, 0, 0);

    foreach (vecs[i]) begin
      step(bit'(vecs[i].rs), bit'(vecs[i].clr), bit'(vecs[i].md));
      chk($sformatf("tbl%0d_cnt", i),  int'(o_counter), vecs[i].cnt);
      chk($sformatf("tbl%0d_run", i),  int'(o_run), vecs[i].run);
      chk($sformatf("tbl%0d_tick", i), int'(o_tick), vecs[i].tick);
      chk($sformatf("tbl%0d_wrap", i), int'(o_wrap), vecs[i].wrap);
    end

    // Pause at prescaler=2, hold 10 cycles, resume: next increment two edges on.
    step(1, 0, 0);
    chk("pause_run", int'(o_run), 0);
    repeat (10) step(0, 0, bit'($urandom_range(0, 1)));
    chk("pause_frozen", int'(o_counter), 1);
    step(1, 0, 0);
    chk("resume_run", int'(o_run), 1);
    chk("resume_hold", int'(o_counter), 1);
    step(0, 0, 0);
    chk("resume_inc", int'(o_counter), 2);
    chk("resume_tick", int'(o_tick), 1);

    // Stop coinciding with the terminal event at count 5.
    for (int k = 0; k < 40 && !(m_cnt == 5 && m_phase == DIV - 1); k++) step(0, 0, 0);
    chk("pre_coinc_cnt", int'(o_counter), 5);
    step(1, 0, 0);
    chk("coinc_cnt", int'(o_counter), 6);
    chk("coinc_tick", int'(o_tick), 1);
    chk("coinc_run", int'(o_run), 0);

    // Clear, then wrap down through 0 and up through MAX_COUNT.
    step(0, 1, 0);
    step(0, 0, 0);
    chk("clear_cnt", int'(o_counter), 0);
    step(1, 0, 1);
    run_to_tick(1, "dn_wrap");
    chk("dn_wrap_cnt", int'(o_counter), 9999);
    chk("dn_wrap_w", int'(o_wrap), 1);
    run_to_tick(1, "dn_9998");
    chk("dn_9998_cnt", int'(o_counter), 9998);
    chk("dn_9998_w", int'(o_wrap), 0);
    run_to_tick(0, "up_9999");
    chk("up_9999_cnt", int'(o_counter), 9999);
    chk("up_9999_w", int'(o_wrap), 0);
    run_to_tick(0, "up_wrap");
    chk("up_wrap_cnt", int'(o_counter), 0);
    chk("up_wrap_w", int'(o_wrap), 1);
    step(0, 0, 0);
    chk("wrap_one_cycle", int'(o_wrap), 0);
    run_to_tick(0, "up_1");
    chk("up_1_cnt", int'(o_counter), 1);
    run_to_tick(1, "dn_0");
    chk("dn_0_cnt", int'(o_counter), 0);
    chk("dn_0_w", int'(o_wrap), 0);
    run_to_tick(1, "dn_wrap2");
    chk("dn_wrap2_cnt", int'(o_counter), 9999);
    chk("dn_wrap2_w", int'(o_wrap), 1);

    // Asynchronous reset between edges while running.
    step(0, 0, 0);
    #2;
    i_reset_n = 0;
    #1;
    check_zero("async_rst");
    model_reset();
    @(posedge i_clk);
    @(posedge i_clk);
    #3;
    i_reset_n = 1;
    repeat (6) step(0, 0, 0);
    chk("post_rst_idle", int'(o_counter), 0);
    step(1, 0, 0);
    run_to_tick(0, "post_rst");
    chk("post_rst_cnt", int'(o_counter), 1);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      step(bit'($urandom_range(0, 7) == 0), bit'($urandom_range(0, 9) == 0),
           bit'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
